// File: rtl/fir_coef_sched.sv
// Coefficient scheduler for the 16-tap FIR: shadow/active banks, sample strobe divider,
// and boundary-aligned bank swap. Define FIR_COEF_SYM_EN for mirrored (linear-phase) loading.
module fir_coef_sched #(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned CW    = 12,
    parameter int unsigned AW    = 4,
    parameter int unsigned DIV   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [CW-1:0]         wr_data,
    input  logic                  commit,
    output logic                  busy,
    output logic                  control,
    output logic [NTAPS*CW-1:0]   coef_bus,
    output logic                  coef_upd
);

    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DCW-1:0] div_cnt;
    logic           wr_fire;
    logic           at_last;
    logic           boundary;
    logic           swap;
    logic           wr_ready_nxt;
    logic           busy_nxt;

    assign wr_fire  = wr_valid && wr_ready;
    assign at_last  = (div_cnt == DIV_LAST);
    assign boundary = (run && at_last) || !run;

    // Sample strobe divider; counter parks at zero while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            control <= 1'b0;
        end else begin
            control <= run && at_last;
            if (!run || at_last) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DCW'(1);
            end
        end
    end

    // Commit sequencing: hold the request until the next sample boundary.
    always_comb begin
        state_nxt    = state;
        swap         = 1'b0;
        wr_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (boundary) begin
                    swap      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == PEND) begin
            wr_ready_nxt = 1'b0;
            busy_nxt     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            coef_upd <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ready <= wr_ready_nxt;
            busy     <= busy_nxt;
            coef_upd <= swap;
        end
    end

    // Per-tap shadow and active registers.
    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic [CW-1:0] sh_q;
        logic [CW-1:0] act_q;
        logic          hit;

`ifdef FIR_COEF_SYM_EN
        // Upper half mirrors the lower-half address; upper addresses hit nothing.
        if (k < NTAPS / 2) begin : g_lo
            assign hit = wr_fire && (wr_addr == AW'(k));
        end else begin : g_hi
            assign hit = wr_fire && (wr_addr == AW'(NTAPS - 1 - k));
        end
`else
        assign hit = wr_fire && (wr_addr == AW'(k));
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sh_q  <= '0;
                act_q <= '0;
            end else begin
                if (hit) begin
                    sh_q <= wr_data;
                end
                if (swap) begin
                    act_q <= sh_q;
                end
            end
        end

        assign coef_bus[k*CW +: CW] = act_q;
    end

endmodule

// File: tb/tb_fir_coef_sched.sv
// Self-checking bench for fir_coef_sched: scoreboard of committed banks checked on every coef_upd.
`timescale 1ns/1ps
module tb_fir_coef_sched;

    localparam int unsigned NTAPS = 16;
    localparam int unsigned CW    = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned DIV   = 10;
    localparam int unsigned BW    = NTAPS * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CW-1:0] wr_data = '0;
    logic          commit = 1'b0;
    logic          wr_ready;
    logic          busy;
    logic          control;
    logic [BW-1:0] coef_bus;
    logic          coef_upd;

    int            n_checks = 0;
    int            n_fail = 0;
    int            last_wait = 0;
    logic [CW-1:0] sh [NTAPS];
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] old_bank;
    logic [BW-1:0] new_bank;
    int            coefs [NTAPS] = '{-99, 65, 136, 33, -156, -86, 376, 854,
                                     854, 376, -86, -156, 33, 136, 65, -99};

    fir_coef_sched #(.NTAPS(NTAPS), .CW(CW), .AW(AW), .DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .commit   (commit),
        .busy     (busy),
        .control  (control),
        .coef_bus (coef_bus),
        .coef_upd (coef_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] bank_of();
        logic [BW-1:0] b;
        for (int k = 0; k < NTAPS; k++) b[k*CW +: CW] = sh[k];
        return b;
    endfunction

    function automatic logic [CW-1:0] tap(input int k);
        return coef_bus[k*CW +: CW];
    endfunction

    task automatic model_wr(input int addr, input int data);
`ifdef FIR_COEF_SYM_EN
        if (addr < NTAPS / 2) begin
            sh[addr]             = CW'(data);
            sh[NTAPS - 1 - addr] = CW'(data);
        end
`else
        if (addr < NTAPS) sh[addr] = CW'(data);
`endif
    endtask

    task automatic clear_model();
        for (int k = 0; k < NTAPS; k++) sh[k] = '0;
    endtask

    // Drive one write and hold it until the handshake completes (bounded).
    task automatic wr(input int addr, input int data);
        int  n = 0;
        bit  acc = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = AW'(addr);
        wr_data  = CW'(data);
        while (!acc && n < 50) begin
            acc = wr_ready;
            tick();
            n++;
        end
        wr_valid  = 1'b0;
        last_wait = n;
        if (!acc) check("wr_timeout", 0, 1);
        else model_wr(addr, data);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        exp_q.push_back(bank_of());
        tick();
        commit = 1'b0;
    endtask

    // Scoreboard: every coef_upd must present the oldest outstanding committed bank.
    always @(negedge clk) begin
        if (coef_upd === 1'b1) begin
            if (exp_q.size() == 0) check("upd_unexpected", 1, 0);
            else check("upd_bank", coef_bus, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_model();
        #2 rst = 1'b0;
        #1;
        check("rst_bus", coef_bus, '0);
        check("rst_ready", wr_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ctrl", control, 0);
        check("rst_upd", coef_upd, 0);
        #20 rst = 1'b1;
        tick();
        check("ready_after_rst", wr_ready, 1);

        // Full bank load and commit with run=0.
`ifdef FIR_COEF_SYM_EN
        for (int i = 0; i < NTAPS / 2; i++) wr(i, coefs[i]);
`else
        for (int i = 0; i < NTAPS; i++) wr(i, coefs[i]);
`endif
        do_commit();
        check("t1_busy", busy, 1);
        check("t1_ready_pend", wr_ready, 0);
        check("t1_upd_early", coef_upd, 0);
        tick();
        check("t1_upd", coef_upd, 1);
        check("t1_busy_clr", busy, 0);
        check("t1_tap0", tap(0), 12'hF9D);
        check("t1_tap7", tap(7), 12'h356);
        check("t1_tap2", tap(2), 12'h088);
        check("t1_tap15", tap(15), 12'hF9D);

        // Strobe cadence: one pulse per DIV cycles, first after DIV cycles.
        run = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("t2_ctrl", control, ((i % DIV) == 0) ? 1 : 0);
        end
        run = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t2_ctrl_idle", control, 0);
        end

        // Mid-period commit waits for the sample boundary.
        old_bank = bank_of();
        wr(3, 'h7FF);
        new_bank = bank_of();
        run = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        do_commit();
        check("t3_busy", busy, 1);
        for (int j = 0; j < 5; j++) begin
            tick();
            check("t3_hold_bus", coef_bus, old_bank);
            check("t3_hold_ready", wr_ready, 0);
            check("t3_hold_ctrl", control, 0);
        end
        tick();
        check("t3_upd", coef_upd, 1);
        check("t3_ctrl_sync", control, 1);
        check("t3_bus", coef_bus, new_bank);
        check("t3_busy_clr", busy, 0);

        // Write stalls while pending, lands in shadow only after the swap.
        do_commit();
        wr(2, 'h001);
        check("t4_stall_cycles", last_wait, 10);
        check("t4_tap2_active", tap(2), 12'h088);
        check("t4_busy", busy, 0);

        // Write and commit in the same cycle: the write is part of the commit.
        run      = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = AW'(2);
        wr_data  = CW'('h0A5);
        commit   = 1'b1;
        model_wr(2, 'h0A5);
        exp_q.push_back(bank_of());
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        check("t4_busy_pend", busy, 1);
        tick();
        check("t4_upd", coef_upd, 1);
        check("t4_tap2_new", tap(2), 12'h0A5);

        // Asynchronous reset while pending discards the commit.
        run = 1'b1;
        do_commit();
        check("t5_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_bus_clr", coef_bus, '0);
        check("t5_busy_clr", busy, 0);
        check("t5_ready_clr", wr_ready, 0);
        check("t5_ctrl_clr", control, 0);
        exp_q.delete();
        clear_model();
        run = 1'b0;
        #5 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t5_no_upd", coef_upd, 0);
        end
        check("t5_bus_zero", coef_bus, '0);

`ifdef FIR_COEF_SYM_EN
        // Mirrored load; upper-half addresses are dropped.
        wr(7, 854);
        wr(0, -99);
        wr(9, 'h555);
        do_commit();
        tick();
        check("t6_upd", coef_upd, 1);
        check("t6_tap7", tap(7), 12'h356);
        check("t6_tap8", tap(8), 12'h356);
        check("t6_tap0", tap(0), 12'hF9D);
        check("t6_tap15", tap(15), 12'hF9D);
        check("t6_tap9", tap(9), 12'h000);
        check("t6_tap6", tap(6), 12'h000);
`else
        // Boundary taps affect only their own slot.
        wr(15, -99);
        wr(0, 854);
        do_commit();
        tick();
        check("t6_upd", coef_upd, 1);
        check("t6_tap15", tap(15), 12'hF9D);
        check("t6_tap0", tap(0), 12'h356);
        check("t6_tap1", tap(1), 12'h000);
        check("t6_tap14", tap(14), 12'h000);
`endif

        tick();
        check("q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
